// File: rtl/sipo_frame_ctrl.sv
// sipo_frame_ctrl: framed serial receiver. It waits for a start bit,
// shifts WIDTH data bits into a SIPO register (first bit ends up in the
// MSB) and checks the stop bit. Good words go into a single-entry
// holding register. The controller also keeps sticky framing/overrun
// flags and a wrapping count of delivered words.
//
// Consumer handshake: word_valid is high while the holding register is
// full. A word is transferred on any rising edge where word_valid and
// word_ready are both high. word_ready may be high at any time and has
// no effect while word_valid is low. word_out is stable while
// word_valid is high, and keeps its last value after the pop. If a new
// word is loaded on the same edge as a pop, word_valid stays high with
// the new data.
module sipo_frame_ctrl #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             serial_in,
  input  logic             word_ready,
  input  logic             err_clear,
  output logic [WIDTH-1:0] word_out,
  output logic             word_valid,
  output logic             shift_en,
  output logic             busy,
  output logic             framing_err,
  output logic             overrun_err,
  output logic [CNT_W-1:0] frame_count,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DATA = 2'd1,
    S_STOP = 2'd2
  } state_t;

  localparam int BC_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0]   shreg_q, shreg_d;
  logic [WIDTH-1:0]   word_q, word_d;
  logic               valid_q, valid_d;
  logic               fe_q, fe_d;
  logic               ov_q, ov_d;
  logic [CNT_W-1:0]   count_q, count_d;

  // Set in the STOP cycle while the receiver is still armed.
  logic stop_eval;
  logic stop_good;
  logic slot_free;
  logic load;
  logic pop;
  logic fe_set;
  logic ov_set;

  // State, datapath and bookkeeping registers. Reset clears everything at once.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      fe_q      <= 1'b0;
      ov_q      <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      fe_q      <= fe_d;
      ov_q      <= ov_d;
      count_q   <= count_d;
    end
  end

  // Frame sequencing: start detection, data shifting, stop-bit evaluation.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    stop_eval = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (enable && serial_in) begin
          state_d   = S_DATA;
          bit_cnt_d = '0;
        end
      end
      S_DATA: begin
        if (!enable) begin
          state_d = S_IDLE;
        end else begin
          shreg_d   = {shreg_q[WIDTH-2:0], serial_in};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_STOP;
          end
        end
      end
      S_STOP: begin
        state_d   = S_IDLE;
        stop_eval = enable;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Holding register, handshake, sticky flags and frame counter.
  always_comb begin
    stop_good = stop_eval & ~serial_in;
    slot_free = ~valid_q | word_ready;
    load      = stop_good & slot_free;
    ov_set    = stop_good & ~slot_free;
    fe_set    = stop_eval & serial_in;
    pop       = valid_q & word_ready;

    valid_d   = load | (valid_q & ~pop);
    word_d    = load ? shreg_q : word_q;
    count_d   = load ? count_q + 1'b1 : count_q;
    // A flag being set on the same edge as err_clear stays set.
    fe_d      = fe_set | (fe_q & ~err_clear);
    ov_d      = ov_set | (ov_q & ~err_clear);
  end

  assign word_out    = word_q;
  assign word_valid  = valid_q;
  assign shift_en    = (state_q == S_DATA);
  assign busy        = (state_q != S_IDLE);
  assign framing_err = fe_q;
  assign overrun_err = ov_q;
  assign frame_count = count_q;
  assign fsm_state   = state_q;

endmodule

// File: tb/tb_sipo_frame_ctrl.sv
// Testbench for sipo_frame_ctrl: directed scenarios plus randomized
// traffic checked against a frame-level reference model.
module tb_sipo_frame_ctrl;

  localparam int W  = 4;
  localparam int CW = 8;

  // ---------------- clock / reset / DUT ----------------
  logic          clock = 1'b0;
  logic          reset;
  logic          enable;
  logic          serial_in;
  logic          word_ready;
  logic          err_clear;
  logic [W-1:0]  word_out;
  logic          word_valid;
  logic          shift_en;
  logic          busy;
  logic          framing_err;
  logic          overrun_err;
  logic [CW-1:0] frame_count;
  logic [1:0]    fsm_state;

  always #5 clock = ~clock;

  sipo_frame_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
    .clock       (clock),
    .reset       (reset),
    .enable      (enable),
    .serial_in   (serial_in),
    .word_ready  (word_ready),
    .err_clear   (err_clear),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .shift_en    (shift_en),
    .busy        (busy),
    .framing_err (framing_err),
    .overrun_err (overrun_err),
    .frame_count (frame_count),
    .fsm_state   (fsm_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];   // words the model says were popped
  logic [W-1:0] got_q[$];   // words observed on word_out at each pop

  // ---------------- reference model ----------------
  // m_pos: -1 idle, 0..W-1 number of data bits collected, W awaiting stop.
  int           m_pos;
  int           m_acc;
  logic [W-1:0] m_word;
  logic         m_valid;
  logic         m_fe;
  logic         m_ov;
  int           m_count;

  function automatic void model_reset();
    m_pos   = -1;
    m_acc   = 0;
    m_word  = '0;
    m_valid = 1'b0;
    m_fe    = 1'b0;
    m_ov    = 1'b0;
    m_count = 0;
  endfunction

  function automatic void model_edge(input logic en, input logic sin,
                                     input logic rdy, input logic clr);
    logic fe_set, ov_set, load, pop;
    fe_set = 1'b0;
    ov_set = 1'b0;
    load   = 1'b0;
    pop    = m_valid && rdy;
    if (m_pos < 0) begin
      if (en && sin) begin
        m_pos = 0;
        m_acc = 0;
      end
    end else if (!en) begin
      m_pos = -1;
    end else if (m_pos < W) begin
      m_acc = (m_acc * 2 + (sin ? 1 : 0)) % (1 << W);
      m_pos = m_pos + 1;
    end else begin
      m_pos = -1;
      if (sin) fe_set = 1'b1;
      else if (!m_valid || rdy) load = 1'b1;
      else ov_set = 1'b1;
    end
    if (pop) exp_q.push_back(m_word);
    if (load) begin
      m_word  = m_acc[W-1:0];
      m_valid = 1'b1;
      m_count = (m_count + 1) % (1 << CW);
    end else if (pop) begin
      m_valid = 1'b0;
    end
    m_fe = fe_set || (m_fe && !clr);
    m_ov = ov_set || (m_ov && !clr);
  endfunction

  // ---------------- driver tasks ----------------
  // Applies inputs for one cycle, advances the model, returns 1 ns after the edge.
  task automatic drive(input logic en, input logic sin, input logic rdy, input logic clr);
    enable     = en;
    serial_in  = sin;
    word_ready = rdy;
    err_clear  = clr;
    if (word_valid && rdy) got_q.push_back(word_out);
    model_edge(en, sin, rdy, clr);
    @(posedge clock);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] data, input logic stop, input logic rdy_stop);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = W - 1; i >= 0; i--) drive(1'b1, data[i], 1'b0, 1'b0);
    drive(1'b1, stop, rdy_stop, 1'b0);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; serial_in = 1'b0; word_ready = 1'b0; err_clear = 1'b0;
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({word_out, word_valid, frame_count} !== '0) begin
      errors++;
      $display("FAIL reset_data: word_out=%0h valid=%0b count=%0d, required all 0", word_out, word_valid, frame_count);
    end
    checks++;
    if ({shift_en, busy, framing_err, overrun_err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_status: shift/busy/fe/ov=%04b, required 0000", {shift_en, busy, framing_err, overrun_err});
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_good_frame();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, shift_en} !== 2'b11) begin
      errors++;
      $display("FAIL good_in_data: busy/shift=%02b, required 11", {busy, shift_en});
    end
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, shift_en, word_valid} !== 3'b100) begin
      errors++;
      $display("FAIL good_in_stop: busy/shift/valid=%03b, required 100", {busy, shift_en, word_valid});
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    checks++;
    if ({word_out, word_valid} !== {4'b1011, 1'b1} || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL good_word: word=%b valid=%0b count=%0d, required 1011/1/1", word_out, word_valid, frame_count);
    end
    checks++;
    if ({busy, framing_err, overrun_err} !== 3'b000) begin
      errors++;
      $display("FAIL good_flags: busy/fe/ov=%03b, required 000", {busy, framing_err, overrun_err});
    end
  endtask

  task automatic test_reset_mid_frame();
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if ({word_out, word_valid, shift_en, busy, framing_err, overrun_err, frame_count} !== '0) begin
      errors++;
      $display("FAIL async_reset: word=%b valid=%0b shift=%0b busy=%0b count=%0d, required all 0",
               word_out, word_valid, shift_en, busy, frame_count);
    end
    model_reset();
    #1;
    reset = 1'b0;
    send_frame(4'b0110, 1'b0, 1'b0);
    checks++;
    if ({word_out, word_valid} !== {4'b0110, 1'b1} || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL after_reset_word: word=%b valid=%0b count=%0d, required 0110/1/1", word_out, word_valid, frame_count);
    end
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    checks++;
    if ({word_out, word_valid} !== {4'b0110, 1'b0}) begin
      errors++;
      $display("FAIL pop_hold: word=%b valid=%0b, required 0110/0", word_out, word_valid);
    end
  endtask

  task automatic test_framing();
    send_frame(4'b0110, 1'b1, 1'b0);
    checks++;
    if ({framing_err, overrun_err, word_valid} !== 3'b100 || frame_count !== 8'd1) begin
      errors++;
      $display("FAIL framing_set: fe/ov/valid=%03b count=%0d, required 100/1", {framing_err, overrun_err, word_valid}, frame_count);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if (framing_err !== 1'b0) begin
      errors++;
      $display("FAIL framing_clear: fe=%0b, required 0", framing_err);
    end
    // Bad stop bit on the same edge as err_clear: the set wins.
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < W; i++) drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (framing_err !== 1'b1) begin
      errors++;
      $display("FAIL framing_set_wins: fe=%0b, required 1", framing_err);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_overrun();
    send_frame(4'b1011, 1'b0, 1'b0);
    send_frame(4'b0110, 1'b0, 1'b0);
    checks++;
    if ({word_out, word_valid} !== {4'b1011, 1'b1} || frame_count !== 8'd2) begin
      errors++;
      $display("FAIL overrun_word: word=%b valid=%0b count=%0d, required 1011/1/2", word_out, word_valid, frame_count);
    end
    checks++;
    if ({overrun_err, framing_err} !== 2'b10) begin
      errors++;
      $display("FAIL overrun_flag: ov/fe=%02b, required 10", {overrun_err, framing_err});
    end
  endtask

  task automatic test_pop_load();
    drive(1'b0, 1'b0, 1'b0, 1'b1);
    checks++;
    if ({overrun_err, word_valid} !== 2'b01) begin
      errors++;
      $display("FAIL ov_clear: ov/valid=%02b, required 01", {overrun_err, word_valid});
    end
    send_frame(4'b0110, 1'b0, 1'b1);
    checks++;
    if ({word_out, word_valid, overrun_err} !== {4'b0110, 2'b10} || frame_count !== 8'd3) begin
      errors++;
      $display("FAIL pop_load: word=%b valid=%0b ov=%0b count=%0d, required 0110/1/0/3", word_out, word_valid, overrun_err, frame_count);
    end
    checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1] !== 4'b1011) begin
      errors++;
      $display("FAIL pop_load_popped: queue size=%0d, required last popped word 1011", got_q.size());
    end
  endtask

  task automatic test_abort();
    drive(1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    checks++;
    if ({busy, shift_en, framing_err, overrun_err, word_valid} !== 5'b00000 || frame_count !== 8'd3) begin
      errors++;
      $display("FAIL abort: busy/shift/fe/ov/valid=%05b count=%0d, required 00000/3",
               {busy, shift_en, framing_err, overrun_err, word_valid}, frame_count);
    end
    send_frame(4'b1001, 1'b0, 1'b0);
    checks++;
    if ({word_out, word_valid} !== {4'b1001, 1'b1} || frame_count !== 8'd4) begin
      errors++;
      $display("FAIL after_abort: word=%b valid=%0b count=%0d, required 1001/1/4", word_out, word_valid, frame_count);
    end
  endtask

  // 256 back-to-back frames, each stop edge also pops the previous word.
  task automatic test_back_to_back_wrap();
    logic [W-1:0] d;
    d = '0;
    for (int n = 0; n < 256; n++) begin
      d = W'($urandom_range(0, (1 << W) - 1));
      send_frame(d, 1'b0, 1'b1);
    end
    checks++;
    if ({word_out, word_valid, overrun_err} !== {d, 2'b10}) begin
      errors++;
      $display("FAIL b2b_last: word=%b valid=%0b ov=%0b, required %b/1/0", word_out, word_valid, overrun_err, d);
    end
    checks++;
    if (frame_count !== 8'd4) begin
      errors++;
      $display("FAIL count_wrap: count=%0d, required 4", frame_count);
    end
  endtask

  task automatic test_random();
    logic en, sin, rdy, clr;
    logic [W+CW+4:0] got, exp;
    for (int c = 0; c < 3000; c++) begin
      en  = ($urandom_range(0, 15) != 0);
      sin = 1'($urandom_range(0, 1));
      rdy = ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 19) == 0);
      drive(en, sin, rdy, clr);
      got = {word_out, word_valid, shift_en, busy, framing_err, overrun_err, frame_count};
      exp = {m_word, m_valid, (m_pos >= 0 && m_pos < W), (m_pos >= 0), m_fe, m_ov, m_count[CW-1:0]};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random_cycle%0d: got=%h required=%h", c, got, exp);
      end
    end
  endtask

  task automatic test_scoreboard();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL pop_count: popped=%0d required=%0d", got_q.size(), exp_q.size());
    end else begin
      for (int i = 0; i < exp_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL popped_word%0d: got=%b required=%b", i, got_q[i], exp_q[i]);
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_good_frame();
    test_reset_mid_frame();
    test_framing();
    test_overrun();
    test_pop_load();
    test_abort();
    test_back_to_back_wrap();
    test_random();
    test_scoreboard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
